// File: rtl/srp_array_mem.sv
// srp_array_mem: multi-port on-chip array memory for synthesised kernels.
// After reset a hardware clear sequence writes INIT_VALUE to every word,
// then the memory serves N_PORTS independent read/write ports.
//
// Ports
//   clk          rising-edge clock
//   rst          synchronous active-high reset; restarts the clear sequence
//   wenable      per-port write enable, bit p = port p
//   addr         per-port address, port p at [p*ADDR_W +: ADDR_W]
//   wdata        per-port signed write data, port p at [p*DATA_W +: DATA_W]
//   rdata        per-port signed read data, READ_LAT cycles after the address
//   ready        high once the clear sequence has finished
//   err_oob      sticky: some port presented addr >= DEPTH while ready
//   err_collide  sticky: two or more ports wrote the same address in a cycle
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_CLEAR | writing INIT_VALUE to mem[ptr]; ports ignored, rdata = 0
// S_READY | normal operation, one access per port per cycle
module srp_array_mem #(
    parameter int              DATA_W     = 64,
    parameter int              ADDR_W     = 1,
    parameter int              DEPTH      = 2,
    parameter int              N_PORTS    = 1,
    parameter int              READ_LAT   = 1,
    parameter logic [DATA_W-1:0] INIT_VALUE = '0
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [N_PORTS-1:0]          wenable,
    input  logic [N_PORTS*ADDR_W-1:0]   addr,
    input  logic [N_PORTS*DATA_W-1:0]   wdata,
    output logic [N_PORTS*DATA_W-1:0]   rdata,
    output logic                        ready,
    output logic                        err_oob,
    output logic                        err_collide
);

    // Storage spans the full address space so every index is in bounds;
    // words at or above DEPTH are never written and their reads are masked.
    localparam int                MEM_WORDS = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    typedef enum logic {S_CLEAR, S_READY} state_t;

    state_t              state;
    logic [ADDR_W-1:0]   ptr;
    logic [DATA_W-1:0]   mem [MEM_WORDS];

    logic [ADDR_W-1:0]   a   [N_PORTS];
    logic [DATA_W-1:0]   wd  [N_PORTS];
    logic [DATA_W-1:0]   rd1 [N_PORTS];
    logic [N_PORTS-1:0]  in_rng;
    logic                any_oob;
    logic                any_collide;

    always_comb begin
        any_collide = 1'b0;
        for (int p = 0; p < N_PORTS; p++) begin
            a[p]      = addr[p*ADDR_W +: ADDR_W];
            wd[p]     = wdata[p*DATA_W +: DATA_W];
            in_rng[p] = (32'(a[p]) < DEPTH);
        end
        any_oob = ~&in_rng;
        for (int p = 0; p < N_PORTS; p++) begin
            for (int q = p + 1; q < N_PORTS; q++) begin
                if (wenable[p] && wenable[q] && in_rng[p] && in_rng[q] &&
                    (a[p] == a[q])) begin
                    any_collide = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_CLEAR;
            ptr         <= '0;
            ready       <= 1'b0;
            err_oob     <= 1'b0;
            err_collide <= 1'b0;
        end else begin
            case (state)
                S_CLEAR: begin
                    ptr <= ptr + 1'b1;
                    if (ptr == LAST_ADDR) begin
                        state <= S_READY;
                        ready <= 1'b1;
                        ptr   <= '0;
                    end
                end
                S_READY: begin
                    if (any_oob)     err_oob     <= 1'b1;
                    if (any_collide) err_collide <= 1'b1;
                end
                default: state <= S_CLEAR;
            endcase
        end
    end

    // Ports are visited in ascending order, so on a collision the last
    // non-blocking write, from the highest-index port, takes effect.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state == S_CLEAR) begin
                mem[ptr] <= INIT_VALUE;
            end else begin
                for (int p = 0; p < N_PORTS; p++) begin
                    if (wenable[p] && in_rng[p]) mem[a[p]] <= wd[p];
                end
            end
        end
    end

    // Reads sample mem before this edge's writes land: read-first.
    always_ff @(posedge clk) begin
        for (int p = 0; p < N_PORTS; p++) begin
            if (rst || state != S_READY || !in_rng[p]) rd1[p] <= '0;
            else                                       rd1[p] <= mem[a[p]];
        end
    end

    if (READ_LAT == 2) begin : g_lat2
        logic [DATA_W-1:0] rd2 [N_PORTS];

        always_ff @(posedge clk) begin
            for (int p = 0; p < N_PORTS; p++) begin
                if (rst) rd2[p] <= '0;
                else     rd2[p] <= rd1[p];
            end
        end

        always_comb begin
            rdata = '0;
            for (int p = 0; p < N_PORTS; p++) rdata[p*DATA_W +: DATA_W] = rd2[p];
        end
    end else begin : g_lat1
        always_comb begin
            rdata = '0;
            for (int p = 0; p < N_PORTS; p++) rdata[p*DATA_W +: DATA_W] = rd1[p];
        end
    end

endmodule

// File: tb/tb_srp_array_mem.sv
module tb_srp_array_mem;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;

    localparam logic [63:0] M7 = 64'hffff_ffff_ffff_fff9;
    localparam logic [63:0] M5 = 64'hffff_ffff_ffff_fffb;

    logic rst_a, rst_r, rst_d;

    // A: DEPTH=4, INIT=-7 (clear timing, reset mid-operation)
    logic        wen_a;
    logic [1:0]  addr_a;
    logic [63:0] wd_a, rd_a;
    logic        rdy_a, oob_a, col_a;
    srp_array_mem #(.ADDR_W(2), .DEPTH(4), .INIT_VALUE(-64'sd7)) u_a (
        .clk(clk), .rst(rst_a), .wenable(wen_a), .addr(addr_a), .wdata(wd_a),
        .rdata(rd_a), .ready(rdy_a), .err_oob(oob_a), .err_collide(col_a));

    // B: defaults, B2: READ_LAT=2, same stimulus
    logic        wen_b;
    logic [0:0]  addr_b;
    logic [63:0] wd_b, rd_b, rd_b2;
    logic        rdy_b, oob_b, col_b, rdy_b2, oob_b2, col_b2;
    srp_array_mem u_b (
        .clk(clk), .rst(rst_r), .wenable(wen_b), .addr(addr_b), .wdata(wd_b),
        .rdata(rd_b), .ready(rdy_b), .err_oob(oob_b), .err_collide(col_b));
    srp_array_mem #(.READ_LAT(2)) u_b2 (
        .clk(clk), .rst(rst_r), .wenable(wen_b), .addr(addr_b), .wdata(wd_b),
        .rdata(rd_b2), .ready(rdy_b2), .err_oob(oob_b2), .err_collide(col_b2));

    // C: two ports, read-first
    logic [1:0]   wen_c;
    logic [1:0]   addr_c;
    logic [127:0] wd_c, rd_c;
    logic         rdy_c, oob_c, col_c;
    srp_array_mem #(.N_PORTS(2)) u_c (
        .clk(clk), .rst(rst_r), .wenable(wen_c), .addr(addr_c), .wdata(wd_c),
        .rdata(rd_c), .ready(rdy_c), .err_oob(oob_c), .err_collide(col_c));

    // D: three ports, collision
    logic [2:0]   wen_d;
    logic [5:0]   addr_d;
    logic [191:0] wd_d, rd_d;
    logic         rdy_d, oob_d, col_d;
    srp_array_mem #(.N_PORTS(3), .ADDR_W(2), .DEPTH(4)) u_d (
        .clk(clk), .rst(rst_d), .wenable(wen_d), .addr(addr_d), .wdata(wd_d),
        .rdata(rd_d), .ready(rdy_d), .err_oob(oob_d), .err_collide(col_d));

    // E: DEPTH=3 in a 2-bit address space, INIT=8
    logic        wen_e;
    logic [1:0]  addr_e;
    logic [63:0] wd_e, rd_e;
    logic        rdy_e, oob_e, col_e;
    srp_array_mem #(.ADDR_W(2), .DEPTH(3), .INIT_VALUE(64'd8)) u_e (
        .clk(clk), .rst(rst_r), .wenable(wen_e), .addr(addr_e), .wdata(wd_e),
        .rdata(rd_e), .ready(rdy_e), .err_oob(oob_e), .err_collide(col_e));

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic rdy_of(input int w);
        case (w)
            1:       return rdy_b & rdy_b2;
            2:       return rdy_c;
            3:       return rdy_d;
            default: return rdy_e;
        endcase
    endfunction

    task automatic wait_ready(input int w, input string tag);
        int n = 0;
        while (!rdy_of(w) && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!rdy_of(w)) check(tag, 64'd0, 64'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_a = 1; rst_r = 1; rst_d = 1;
        wen_a = 0; addr_a = 0; wd_a = 0;
        wen_b = 0; addr_b = 0; wd_b = 0;
        wen_c = 0; addr_c = 0; wd_c = 0;
        wen_d = 0; addr_d = 0; wd_d = 0;
        wen_e = 0; addr_e = 0; wd_e = 0;
        repeat (3) @(negedge clk);

        check("rst_ready", 64'(rdy_a), 64'd0);
        check("rst_rdata", rd_a, 64'd0);
        check("rst_flags", 64'({oob_a, col_a}), 64'd0);

        // clear timing: ready first seen after the 4th edge
        rst_a = 0; rst_r = 0; rst_d = 0;
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            check("clr_ready", 64'(rdy_a), 64'(i == 4));
            if (i < 4) check("clr_rdata0", rd_a, 64'd0);
        end
        for (int i = 0; i < 4; i++) begin
            addr_a = 2'(i);
            @(negedge clk);
            check("clr_init", rd_a, M7);
        end

        // single port write/read, latency 1 and 2
        wait_ready(1, "b_timeout");
        wen_b = 1; addr_b = 1; wd_b = 64'd21;
        @(negedge clk);
        wen_b = 0;
        @(negedge clk);
        check("b_lat1_rd", rd_b, 64'd21);
        check("b_lat2_pre", rd_b2, 64'd0);
        addr_b = 0;
        @(negedge clk);
        check("b_addr0", rd_b, 64'd0);
        check("b_lat2_rd", rd_b2, 64'd21);
        @(negedge clk);
        check("b_lat2_addr0", rd_b2, 64'd0);

        // read-first with signed data
        wait_ready(2, "c_timeout");
        wen_c = 2'b01; addr_c = 2'b00; wd_c[63:0] = M5; wd_c[127:64] = 64'd3;
        @(negedge clk);
        check("c_readfirst", rd_c[127:64], 64'd0);
        wen_c = 0;
        @(negedge clk);
        check("c_new_p1", rd_c[127:64], M5);
        check("c_new_p0", rd_c[63:0], M5);
        check("c_flags", 64'({oob_c, col_c}), 64'd0);

        // three-way collision on addr 2
        wait_ready(3, "d_timeout");
        check("d_col_pre", 64'(col_d), 64'd0);
        wen_d = 3'b111; addr_d = {2'd2, 2'd2, 2'd2};
        wd_d = {64'd30, 64'd20, 64'd10};
        @(negedge clk);
        check("d_col_set", 64'(col_d), 64'd1);
        wen_d = 0;
        @(negedge clk);
        check("d_winner", rd_d[63:0], 64'd30);
        check("d_winner_p2", rd_d[191:128], 64'd30);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("d_col_sticky", 64'(col_d), 64'd1);
        end
        rst_d = 1;
        @(negedge clk);
        check("d_col_rst", 64'(col_d), 64'd0);
        check("d_ready_rst", 64'(rdy_d), 64'd0);
        rst_d = 0;

        // out-of-range
        wait_ready(4, "e_timeout");
        check("e_oob_pre", 64'(oob_e), 64'd0);
        wen_e = 1; addr_e = 2'd3; wd_e = 64'd99;
        @(negedge clk);
        check("e_oob_set", 64'(oob_e), 64'd1);
        check("e_oob_rd0", rd_e, 64'd0);
        wen_e = 0;
        @(negedge clk);
        check("e_oob_rd1", rd_e, 64'd0);
        for (int i = 0; i < 3; i++) begin
            addr_e = 2'(i);
            @(negedge clk);
            check("e_init", rd_e, 64'd8);
        end
        check("e_oob_sticky", 64'(oob_e), 64'd1);

        // reset mid-operation on A
        addr_a = 1; wen_a = 1; wd_a = 64'd5;
        @(negedge clk);
        wen_a = 0;
        @(negedge clk);
        @(negedge clk);
        check("a_wr5", rd_a, 64'd5);
        rst_a = 1;
        @(negedge clk);
        rst_a = 0; wen_a = 1; addr_a = 2; wd_a = 64'd77;
        @(negedge clk);
        rst_a = 1;
        @(negedge clk);
        check("a_rst2_ready", 64'(rdy_a), 64'd0);
        rst_a = 0;
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            check("a_reclr_ready", 64'(rdy_a), 64'(i == 4));
            check("a_reclr_rd", rd_a, 64'd0);
        end
        wen_a = 0; addr_a = 1;
        @(negedge clk);
        check("a_addr1_init", rd_a, M7);
        addr_a = 2;
        @(negedge clk);
        check("a_addr2_init", rd_a, M7);
        check("a_flags", 64'({oob_a, col_a}), 64'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/srp_array_mem.md
Name: srp_array_mem

Overview:
- Parametrised on-chip array memory for arrays declared in synthesised kernels. The generated `main` module reaches each array through a `<name>WEnable_x / Addr_x / WData_x / RData_x` port group.
- Generalises the single-port, 64-bit, 2-entry array interface to N independent access ports, configurable width, depth and read latency.
- Adds a hardware clear sequence after reset, deterministic write-collision resolution, and sticky error flags.
- Sits between the kernel datapath and the array storage; one instance per array.

Parameters:
- DATA_W, 64, word width in bits; data is treated as signed.
- ADDR_W, 1, address width in bits.
- DEPTH, 2, number of words; must satisfy 1 <= DEPTH <= 2**ADDR_W.
- N_PORTS, 1, number of access ports; legal range 1..4.
- READ_LAT, 1, read latency in cycles; legal values 1 or 2.
- INIT_VALUE, 0, DATA_W-bit value written to every word during the clear sequence.

Ports:
- clk  input  1  clock; all logic is on the rising edge.
- rst  input  1  synchronous, active-high reset.
- wenable  input  N_PORTS  per-port write enable; bit p belongs to port p.
- addr  input  N_PORTS*ADDR_W  per-port address; port p occupies slice [p*ADDR_W +: ADDR_W].
- wdata  input  N_PORTS*DATA_W  per-port write data, signed; sliced the same way as addr.
- rdata  output  N_PORTS*DATA_W  per-port read data, signed.
- ready  output  1  high once the clear sequence has finished and the memory accepts accesses.
- err_oob  output  1  sticky flag: some port issued an access with addr >= DEPTH.
- err_collide  output  1  sticky flag: two or more ports wrote the same address in the same cycle.

Behaviour:
- Reset (rst=1 at a clock edge):
  - state <= CLEAR, clear pointer <= 0.
  - ready, err_oob, err_collide <= 0; all rdata pipeline registers <= 0.
  - Reset during CLEAR or READY restarts the clear sequence from address 0.
- FSM states: CLEAR, READY.
- CLEAR:
  - Each cycle writes INIT_VALUE to mem[ptr], then ptr increments.
  - When ptr = DEPTH-1 has been written, the FSM moves to READY on that same edge.
  - ready rises on the edge that writes the last word, so it is first visible exactly DEPTH cycles after rst is released.
  - While in CLEAR, all port writes are ignored, rdata is held at 0, and neither error flag can be set.
- READY, reads:
  - Every port reads every cycle; there is no read enable.
  - READ_LAT=1: rdata_p = mem[addr_p] as sampled at edge k, visible after edge k.
  - READ_LAT=2: one extra output register stage, so the data appears one cycle later.
- READY, writes:
  - wenable[p]=1 writes wdata_p to mem[addr_p] at the edge.
- Read-during-write, same address, same cycle: read-first.
  - rdata returns the old contents.
  - The new value is visible to a read issued in the next cycle.
- Write collision (several ports write the same in-range address in one cycle):
  - The highest-index port wins.
  - err_collide <= 1.
  - Identical wdata still counts as a collision.
- Out-of-range access (addr_p >= DEPTH) from any port, read or write:
  - The write is suppressed.
  - That port's rdata = 0 at its normal latency.
  - err_oob <= 1.
  - When DEPTH = 2**ADDR_W this case cannot occur.
- Error flags clear only on rst.
- Widths: addresses are unsigned. Data is stored verbatim with no sign extension or truncation.
- Ports are independent, with no arbitration stalls: throughput is one access per port per cycle.

Test Plan:
- Clear timing: DEPTH=4, INIT_VALUE=-7.
  - Release rst → ready=0 for 4 cycles, then 1.
  - Reads of addresses 0..3 all return -7 (64'hffff_ffff_ffff_fff9).
- Single-port write/read: default parameters.
  - Write 21 to addr 1, then read addr 1 the next cycle → rdata=21 after 1 cycle.
  - Addr 0 still returns INIT_VALUE.
  - With READ_LAT=2, the same value appears one cycle later.
- Read-first plus signed data: N_PORTS=2.
  - Port0 writes -5 to addr 0 while port1 reads addr 0 in the same cycle → port1 sees the old value (0).
  - The next cycle it sees -5 (64'hffff_ffff_ffff_fffb).
- Collision: N_PORTS=3.
  - All three ports write addr 2 with values 10/20/30 → mem[2]=30 and err_collide=1.
  - The flag stays 1 for 10 further cycles and clears on rst.
- Out-of-range: DEPTH=3, ADDR_W=2.
  - Port0 writes 99 to addr 3 → no word changes, rdata for addr 3 is 0, err_oob=1.
  - mem[0..2] still hold INIT_VALUE.
- Reset mid-operation:
  - DEPTH=4, write 5 to addr 1, then assert rst in cycle 2 of the following clear sequence.
  - Re-release → ready returns 4 cycles later and addr 1 reads INIT_VALUE.
  - Writes attempted during CLEAR leave no trace.
